// File: rtl/intc_pkg.sv
// Shared definitions for the NUM_IRQ-input interrupt controller:
// register offsets, service state and the priority helper.
package intc_pkg;

  localparam logic [2:0] INTC_MASK_L = 3'd0;
  localparam logic [2:0] INTC_MASK_H = 3'd1;
  localparam logic [2:0] INTC_PEND_L = 3'd2;
  localparam logic [2:0] INTC_PEND_H = 3'd3;
  localparam logic [2:0] INTC_STATUS = 3'd4;
  localparam logic [2:0] INTC_EOI    = 3'd5;

  typedef enum logic {
    INTC_IDLE,
    INTC_SERVICE
  } intc_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } lowest_t;

  function automatic lowest_t lowest_set(input logic [15:0] v);
    lowest_t r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One request line: metastability synchroniser plus a history
// flop giving the synced level and a single-cycle rise pulse.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/interrupt_controller_n.sv
// Parametrised interrupt controller: mask/pending/in-service state,
// registered lowest-index request and an ack/EOI service handshake.
module interrupt_controller_n
  import intc_pkg::*;
#(
  parameter int          NUM_IRQ     = 8,
  parameter int          VEC_W       = 4,
  parameter logic [15:0] EDGE_SEL    = 16'hFFFF,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] MASK_RST    = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               wren,
  input  logic [2:0]         addr,
  input  logic [7:0]         from_cpu,
  output logic [7:0]         to_cpu,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               int_ack,
  output logic               int_rq,
  output logic [VEC_W-1:0]   int_addr,
  output logic               busy
);

  localparam logic [15:0] CH_MASK = 16'((32'd1 << NUM_IRQ) - 32'd1);

  logic [NUM_IRQ-1:0] lvl_raw, rise_raw;
  logic [15:0]        lvl, rise;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_ch
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst),
      .irq  (irq_in[g]),
      .level(lvl_raw[g]),
      .rise (rise_raw[g])
    );
  end

  assign lvl  = 16'(lvl_raw);
  assign rise = 16'(rise_raw);

  intc_state_t      state_q, state_d;
  logic [15:0]      mask_q, mask_d;
  logic [15:0]      pend_q, pend_d;
  logic [VEC_W-1:0] insvc_q, insvc_d;
  logic [VEC_W-1:0] int_addr_q, int_addr_d;
  logic             int_rq_q, int_rq_d;
  logic [7:0]       to_cpu_q, to_cpu_d;

  logic        wr, take, eoi, idle;
  logic [15:0] set, w1c, ack_clr;
  lowest_t     lo;

  always_comb begin
    wr      = ce & wren;
    idle    = (state_q == INTC_IDLE);
    eoi     = wr & (addr == INTC_EOI);
    take    = int_ack & int_rq_q & idle;
    set     = ((rise & EDGE_SEL) | (lvl & ~EDGE_SEL)) & CH_MASK;
    w1c     = '0;
    mask_d  = mask_q;
    if (wr) begin
      case (addr)
        INTC_MASK_L: mask_d[7:0]  = from_cpu;
        INTC_MASK_H: mask_d[15:8] = from_cpu;
        INTC_PEND_L: w1c          = {8'h00, from_cpu};
        INTC_PEND_H: w1c          = {from_cpu, 8'h00};
        default: ;
      endcase
    end
    mask_d  = mask_d & CH_MASK;
    // Level channels stay pending at ack; set beats any clear.
    ack_clr = take ? (EDGE_SEL & (16'd1 << int_addr_q)) : '0;
    pend_d  = ((pend_q & ~w1c & ~ack_clr) | set) & CH_MASK;
    lo      = lowest_set(pend_q & mask_q);

    state_d = state_q;
    insvc_d = insvc_q;
    if (take) begin
      state_d = INTC_SERVICE;
      insvc_d = int_addr_q;
    end else if (eoi) begin
      state_d = INTC_IDLE;
    end

    int_rq_d   = idle & lo.valid & ~take;
    int_addr_d = lo.valid ? VEC_W'(lo.idx) : int_addr_q;

    case (addr)
      INTC_MASK_L: to_cpu_d = mask_q[7:0];
      INTC_MASK_H: to_cpu_d = mask_q[15:8];
      INTC_PEND_L: to_cpu_d = pend_q[7:0];
      INTC_PEND_H: to_cpu_d = pend_q[15:8];
      INTC_STATUS: to_cpu_d = {~idle, int_rq_q, 2'b00, 4'(insvc_q)};
      default:     to_cpu_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INTC_IDLE;
      mask_q     <= MASK_RST & CH_MASK;
      pend_q     <= '0;
      insvc_q    <= '0;
      int_addr_q <= '0;
      int_rq_q   <= 1'b0;
      to_cpu_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      insvc_q    <= insvc_d;
      int_addr_q <= int_addr_d;
      int_rq_q   <= int_rq_d;
      to_cpu_q   <= to_cpu_d;
    end
  end

  assign to_cpu   = to_cpu_q;
  assign int_rq   = int_rq_q;
  assign int_addr = int_addr_q;
  assign busy     = (state_q == INTC_SERVICE);

endmodule

// File: tb/tb_interrupt_controller_n.sv
// Bench for interrupt_controller_n: step table plus hand sequences,
// expected values queued on drive and compared on DUT output.
module tb_interrupt_controller_n;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        wren = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [7:0]  from_cpu = 8'h00;
  logic [7:0]  to_cpu;
  logic [11:0] irq_in = '0;
  logic        int_ack = 1'b0;
  logic        int_rq;
  logic [3:0]  int_addr;
  logic        busy;

  interrupt_controller_n #(
    .NUM_IRQ    (12),
    .VEC_W      (4),
    .EDGE_SEL   (16'hFFFD),
    .SYNC_STAGES(2),
    .MASK_RST   (16'h0000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .wren    (wren),
    .addr    (addr),
    .from_cpu(from_cpu),
    .to_cpu  (to_cpu),
    .irq_in  (irq_in),
    .int_ack (int_ack),
    .int_rq  (int_rq),
    .int_addr(int_addr),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef enum int {K_IRQ, K_WR, K_RD, K_ACK, K_OUT} kind_t;

  typedef struct {
    kind_t       k;
    logic [2:0]  a;
    logic [15:0] d;
    int          n;
    string       nm;
  } step_t;

  typedef struct {
    string       nm;
    logic [15:0] v;
  } exp_t;

  exp_t  sb[$];
  step_t tbl[$];
  int    checks = 0;
  int    errors = 0;

  function automatic step_t st(kind_t k, logic [2:0] a,
                               logic [15:0] d, int n, string nm);
    step_t s;
    s.k = k; s.a = a; s.d = d; s.n = n; s.nm = nm;
    return s;
  endfunction

  function automatic logic [15:0] ob(logic b, logic r, logic [3:0] a);
    return {10'd0, b, r, a};
  endfunction

  function automatic logic [15:0] outs();
    return {10'd0, busy, int_rq, int_addr};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(string nm, logic [15:0] v);
    exp_t e;
    e.nm = nm; e.v = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(logic [15:0] act);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h expected an entry", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
    end
  endtask

  task automatic wr(logic [2:0] a, logic [7:0] d);
    ce = 1'b1; wren = 1'b1; addr = a; from_cpu = d;
    cyc();
    ce = 1'b0; wren = 1'b0;
  endtask

  task automatic rd(logic [2:0] a, logic [7:0] e, string nm);
    addr = a;
    push(nm, 16'(e));
    cyc();
    pop_chk(16'(to_cpu));
  endtask

  task automatic ack();
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
  endtask

  task automatic out(int n, logic [15:0] e, string nm);
    repeat (n) cyc();
    push(nm, e);
    pop_chk(outs());
  endtask

  task automatic run(step_t s);
    case (s.k)
      K_IRQ: begin
        irq_in = s.d[11:0];
        repeat (s.n) cyc();
      end
      K_WR:  wr(s.a, s.d[7:0]);
      K_RD:  rd(s.a, s.d[7:0], s.nm);
      K_ACK: ack();
      K_OUT: out(s.n, s.d, s.nm);
      default: ;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // single edge, masked then unmasked
    tbl.push_back(st(K_IRQ, 0, 16'h008, 3, ""));
    tbl.push_back(st(K_RD,  2, 16'h08, 0, "t1_pend"));
    tbl.push_back(st(K_OUT, 0, ob(0, 0, 0), 0, "t1_masked"));
    tbl.push_back(st(K_WR,  0, 16'h08, 0, ""));
    tbl.push_back(st(K_OUT, 0, ob(0, 1, 3), 1, "t1_rq"));
    tbl.push_back(st(K_ACK, 0, 0, 0, ""));
    tbl.push_back(st(K_OUT, 0, ob(1, 0, 3), 0, "t1_busy"));
    tbl.push_back(st(K_WR,  5, 16'h00, 0, ""));
    // two simultaneous edges, priority and EOI
    tbl.push_back(st(K_IRQ, 0, 16'h024, 3, ""));
    tbl.push_back(st(K_WR,  0, 16'hFF, 0, ""));
    tbl.push_back(st(K_OUT, 0, ob(0, 1, 2), 1, "t2_rq"));
    tbl.push_back(st(K_ACK, 0, 0, 0, ""));
    tbl.push_back(st(K_RD,  4, 16'h82, 0, "t2_status"));
    tbl.push_back(st(K_RD,  2, 16'h20, 0, "t2_pend"));
    tbl.push_back(st(K_RD,  5, 16'h00, 0, "eoi_reads_0"));
    tbl.push_back(st(K_WR,  5, 16'h00, 0, ""));
    tbl.push_back(st(K_OUT, 0, ob(0, 1, 5), 1, "t2_next"));
    tbl.push_back(st(K_ACK, 0, 0, 0, ""));
    tbl.push_back(st(K_WR,  5, 16'h00, 0, ""));
    // edge and W1C on the same edge
    tbl.push_back(st(K_IRQ, 0, 16'h010, 2, ""));
    tbl.push_back(st(K_WR,  2, 16'h10, 0, ""));
    tbl.push_back(st(K_RD,  2, 16'h10, 0, "t4_set_wins"));
    tbl.push_back(st(K_WR,  2, 16'h10, 0, ""));
    tbl.push_back(st(K_OUT, 0, ob(0, 0, 4), 1, "t4_rq_drops"));
    tbl.push_back(st(K_RD,  6, 16'h00, 0, "addr6_reads_0"));
    // upper channels on a 12-input instance
    tbl.push_back(st(K_IRQ, 0, 16'h400, 3, ""));
    tbl.push_back(st(K_WR,  1, 16'hF4, 0, ""));
    tbl.push_back(st(K_RD,  1, 16'h04, 0, "t5_mask_h"));
    tbl.push_back(st(K_RD,  3, 16'h04, 0, "t5_pend_h"));
    tbl.push_back(st(K_OUT, 0, ob(0, 1, 10), 0, "t5_rq"));
    tbl.push_back(st(K_WR,  3, 16'hF0, 0, ""));
    tbl.push_back(st(K_RD,  3, 16'h04, 0, "t5_w1c_hi"));
    tbl.push_back(st(K_ACK, 0, 0, 0, ""));
    tbl.push_back(st(K_OUT, 0, ob(1, 0, 10), 0, "t5_busy"));
    tbl.push_back(st(K_WR,  5, 16'h00, 0, ""));

    repeat (3) cyc();
    push("rst_outs", ob(0, 0, 0));
    pop_chk(outs());
    push("rst_to_cpu", 16'h0);
    pop_chk(16'(to_cpu));
    rst = 1'b1;
    cyc();

    foreach (tbl[i]) run(tbl[i]);

    // level channel 1 held high across ack and EOI
    irq_in = 12'h002;
    out(4, ob(0, 1, 1), "t3_rq");
    ack();
    out(0, ob(1, 0, 1), "t3_busy");
    rd(3'd2, 8'h02, "t3_pend_held");
    wr(3'd2, 8'h02);
    rd(3'd2, 8'h02, "t3_w1c_ignored");
    wr(3'd5, 8'h00);
    out(1, ob(0, 1, 1), "t3_reassert");
    irq_in = 12'h000;
    repeat (2) cyc();
    wr(3'd2, 8'h02);
    rd(3'd2, 8'h00, "t3_w1c_after_drop");
    out(0, ob(0, 0, 1), "t3_rq_gone");

    // reset while busy with pending 0x41
    irq_in = 12'h040;
    out(4, ob(0, 1, 6), "t6_rq");
    ack();
    irq_in = 12'h000;
    cyc();
    irq_in = 12'h041;
    repeat (3) cyc();
    rd(3'd2, 8'h41, "t6_pend");
    rd(3'd4, 8'h86, "t6_status");
    #2;
    rst = 1'b0;
    irq_in = 12'h000;
    #1;
    out(0, ob(0, 0, 0), "t6_async_outs");
    push("t6_async_to_cpu", 16'h0);
    pop_chk(16'(to_cpu));
    repeat (2) cyc();
    rst = 1'b1;
    rd(3'd0, 8'h00, "t6_mask_rst");
    rd(3'd2, 8'h00, "t6_pend_rst");
    rd(3'd4, 8'h00, "t6_status_rst");
    wr(3'd0, 8'hFF);
    out(3, ob(0, 0, 0), "t6_no_req");

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_controller_n.md
Name: interrupt_controller_n

Overview:
- Parametrised successor to the 8-input interrupt controller on the IO bus.
- Takes NUM_IRQ asynchronous request lines. Each line is individually configurable as edge- or level-sensitive.
- Keeps mask, pending and in-service state, and presents a registered request plus lowest-index vector to the NeonFox core.
- Adds an explicit acknowledge/EOI handshake, so there is one interrupt in service at a time.

Parameters:
- NUM_IRQ, 8: number of request inputs. Legal range 1..16.
- VEC_W, 4: width of int_addr. Must satisfy 2**VEC_W >= NUM_IRQ.
- EDGE_SEL, 16'hFFFF: per-channel mode bit. 1 = rising-edge, 0 = active-high level.
- SYNC_STAGES, 2: synchroniser depth per input. Minimum 2.
- MASK_RST, 16'h0000: reset value of the enable mask.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ce  in  1  register window select, decoded on the IO bus
- wren  in  1  IO write strobe, qualified by ce
- addr  in  3  register index
- from_cpu  in  8  write data
- to_cpu  out  8  read data, registered
- irq_in  in  NUM_IRQ  raw request lines, asynchronous to clk
- int_ack  in  1  one-cycle pulse from the core when it takes the vector
- int_rq  out  1  interrupt request to the core, registered
- int_addr  out  VEC_W  vector of the requested channel, registered
- busy  out  1  an interrupt is in service

Behaviour:
Reset
- rst low, asynchronously: synchronisers = 0, edge history = 0, pending = 0, mask = MASK_RST, busy = 0, in_service vector = 0, int_rq = 0, int_addr = 0, to_cpu = 0.
- Reset mid-service discards busy and pending. No EOI is required afterwards.

Register map (addr)
- 0: mask[7:0]. Read/write.
- 1: mask[15:8]. Read/write.
- 2: pending[7:0]. Read. A write clears the pending bits written as 1 (write-1-to-clear).
- 3: pending[15:8]. Read; write-1-to-clear, same as 2.
- 4: status. Read only: {busy, int_rq, 2'b0, in_service vector[3:0]}.
- 5: EOI. A write of any value clears busy. Reads as 0.
- 6, 7: read 0. Writes are ignored.
- Bits at or above NUM_IRQ read 0 and ignore writes.
- to_cpu <= reg[addr] on every clock, regardless of ce. Read data is therefore valid one cycle after addr is presented, which matches the registered-enable read mux on the IO bus.
- A write takes effect on the clock edge where ce & wren.

Input path
- Each irq_in bit passes through SYNC_STAGES flops. Latency from the pin to the synchronised value is SYNC_STAGES cycles.
- Edge channels set pending on synced & ~prev_synced.
- Level channels: pending is forced to 1 every cycle while the synced level is 1. Write-1-to-clear is effective only once the level drops.
- If a set event and a write-1-to-clear hit the same bit in the same cycle, set wins.
- Pending is recorded even while the channel is masked. Unmasking later raises the request.

Request / acknowledge state machine
- States: IDLE (busy=0) and SERVICE (busy=1).
- req_vec = lowest index i with pending[i] & mask[i].
- Each cycle: int_rq <= ~busy & |(pending & mask). When a request exists, int_addr <= req_vec; otherwise int_addr holds.
- IDLE -> SERVICE when int_ack & int_rq. On that edge:
  - busy <= 1
  - in_service <= int_addr
  - pending[int_addr] <= 0 for edge channels (a new edge in the same cycle wins)
  - int_rq <= 0
- int_ack while int_rq = 0, or while busy = 1, is ignored.
- SERVICE -> IDLE on an EOI write. int_rq can reassert on the following cycle.
- An EOI write while IDLE has no effect.
- A mask change affects int_rq on the next clock. If a masked channel loses its request before ack, int_rq drops and no vector is taken.
- Latency from an edge on an enabled, idle channel to int_rq high: SYNC_STAGES + 2 cycles (synchroniser, pending, request register).

Decomposition:
- Package intc_pkg holds:
  - register offset constants: INTC_MASK_L=0, INTC_MASK_H=1, INTC_PEND_L=2, INTC_PEND_H=3, INTC_STATUS=4, INTC_EOI=5
  - typedef intc_state_t {INTC_IDLE, INTC_SERVICE}
  - function lowest_set(vector), returns index and valid
- One sub-module, irq_sync_edge: per-channel synchroniser plus previous-value flop. It outputs synced level and rise pulse, parametrised by SYNC_STAGES, async active-low reset. It is instantiated NUM_IRQ times in a generate loop.

Test Plan:
1. Reset, NUM_IRQ=8, MASK_RST=0, then raise irq_in[3] -> pending reads 8'h08 at addr 2; int_rq stays 0. Write mask 8'h08 -> int_rq=1, int_addr=3 two cycles later.
2. Pulse irq_in[5] and irq_in[2] in the same cycle, mask 8'hFF -> int_addr=2. Ack -> busy=1, status=8'h82, pending=8'h20. EOI -> int_rq=1, int_addr=5 next cycle.
3. Level channel 1 (EDGE_SEL bit1=0) held high, ack + EOI -> pending bit1 re-sets immediately and int_rq reasserts. W1C 8'h02 while high has no effect; after the drop, W1C clears it.
4. Edge arrives on channel 4 in the same cycle as a W1C 8'h10 -> pending bit4 remains 1.
5. NUM_IRQ=12: irq_in[10] edge, mask_h=8'h04 -> int_addr=10, pending_h reads 8'h04. Writes to bits 12-15 read back 0.
6. Assert rst low while busy=1 with pending=8'h41 -> on the same edge, all outputs are 0 and mask=MASK_RST. After release, no request until new edges.
